// File: rtl/temp_pkg.sv
// ============================================================================
// Module      : temp_pkg
// Description : Shared definitions for the temperature scanning block:
//               sensor word width, scheduler state encodings and the
//               four classification levels produced by the comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package temp_pkg;

    localparam int TEMP_W = 16;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        CARREGA  = 3'd1,
        MEDE     = 3'd2,
        REGISTRA = 3'd3,
        FIM      = 3'd4
    } estado_t;

    localparam logic [1:0] NIVEL_NORMAL  = 2'd0;
    localparam logic [1:0] NIVEL_ATENCAO = 2'd1;
    localparam logic [1:0] NIVEL_ALERTA  = 2'd2;
    localparam logic [1:0] NIVEL_CRITICO = 2'd3;

endpackage

`default_nettype wire

// File: rtl/escalonador_temperaturas_comparador.sv
// ============================================================================
// Module      : comparador_temperaturas
// Description : Combinational classifier of one unsigned temperature against
//               four thresholds. First match wins, so non-monotonic limits
//               are tolerated without any ordering check.
// Ports       : temp       - reading to classify
//               lim_temp1-4 - level thresholds
//               nivel      - 0 (<=lim1), 1 (<=lim2), 2 (<=lim3), 3 otherwise
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador_temperaturas
    import temp_pkg::*;
(
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] lim_temp1,
    input  logic [TEMP_W-1:0] lim_temp2,
    input  logic [TEMP_W-1:0] lim_temp3,
    input  logic [TEMP_W-1:0] lim_temp4,
    output logic [1:0]        nivel
);

    // lim_temp4 only bounds the critical band from below by construction
    // (everything above lim3 is critical), so it does not steer the result.
    logic w_lim4_unused;
    assign w_lim4_unused = ^lim_temp4;

    always_comb begin
        nivel = NIVEL_CRITICO;
        if (temp <= lim_temp1) begin
            nivel = NIVEL_NORMAL;
        end else if (temp <= lim_temp2) begin
            nivel = NIVEL_ATENCAO;
        end else if (temp <= lim_temp3) begin
            nivel = NIVEL_ALERTA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/escalonador_temperaturas.sv
// ============================================================================
// Module      : escalonador_temperaturas
// Description : Scans N_SENSORES readings through one shared comparator,
//               double-buffers the per-sensor levels and their maximum, and
//               raises an over-temperature alarm after ALARME_SCANS
//               consecutive scans whose maximum is critical.
// Ports       : clock, reset (async, active-high)
//               iniciar   - start a scan (sampled only when idle)
//               continuo  - restart immediately after each scan
//               temps     - sensor i at temps[16*i +: 16]
//               lim_temp1-4 - thresholds, snapshotted at scan start
//               niveis    - sensor i level at niveis[2*i +: 2]
//               nivel_max - maximum of niveis
//               pronto    - one-cycle pulse, coincident with fresh niveis
//               ocupado   - high whenever a scan is in progress
//               alarme    - debounced over-temperature flag
//               db_estado - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module escalonador_temperaturas
    import temp_pkg::*;
#(
    parameter int N_SENSORES   = 4,
    parameter int ALARME_SCANS = 3
)
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic                         continuo,
    input  logic [TEMP_W*N_SENSORES-1:0] temps,
    input  logic [TEMP_W-1:0]            lim_temp1,
    input  logic [TEMP_W-1:0]            lim_temp2,
    input  logic [TEMP_W-1:0]            lim_temp3,
    input  logic [TEMP_W-1:0]            lim_temp4,
    output logic [2*N_SENSORES-1:0]      niveis,
    output logic [1:0]                   nivel_max,
    output logic                         pronto,
    output logic                         ocupado,
    output logic                         alarme,
    output logic [2:0]                   db_estado
);

    localparam int IDX_W = (N_SENSORES > 1) ? $clog2(N_SENSORES) : 1;
    localparam int CNT_W = $clog2(ALARME_SCANS + 1);

    localparam logic [IDX_W-1:0] C_IDX_ULTIMO = IDX_W'(N_SENSORES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = CNT_W'(ALARME_SCANS);

    estado_t                 r_estado;
    estado_t                 w_proximo;
    logic [IDX_W-1:0]        r_idx;
    logic [TEMP_W-1:0]       r_temp_sel;
    logic [TEMP_W-1:0]       w_temp_mux;
    logic [TEMP_W-1:0]       r_lim1;
    logic [TEMP_W-1:0]       r_lim2;
    logic [TEMP_W-1:0]       r_lim3;
    logic [TEMP_W-1:0]       r_lim4;
    logic [1:0]              r_shadow [N_SENSORES];
    logic [1:0]              r_max;
    logic [1:0]              w_nivel;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_ultimo;
    logic [2*N_SENSORES-1:0] r_niveis;
    logic [1:0]              r_nivel_max;
    logic                    r_pronto;
    logic                    r_alarme;

    assign w_ultimo  = (r_idx == C_IDX_ULTIMO);
    // Saturating increment: the counter holds at ALARME_SCANS instead of wrapping.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // ------------------------------------------------------------------
    // Shared comparator: always sees the sampled reading and the limit
    // snapshot, never the live limit inputs.
    // ------------------------------------------------------------------
    comparador_temperaturas u_comparador (
        .temp      (r_temp_sel),
        .lim_temp1 (r_lim1),
        .lim_temp2 (r_lim2),
        .lim_temp3 (r_lim3),
        .lim_temp4 (r_lim4),
        .nivel     (w_nivel)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            OCIOSO:   if (iniciar) w_proximo = CARREGA;
            CARREGA:  w_proximo = MEDE;
            MEDE:     w_proximo = REGISTRA;
            REGISTRA: w_proximo = w_ultimo ? FIM : MEDE;
            FIM:      w_proximo = continuo ? CARREGA : OCIOSO;
            default:  w_proximo = OCIOSO;
        endcase
    end

    // Reading selected by the scan index.
    always_comb begin
        w_temp_mux = temps[TEMP_W-1:0];
        for (int i = 0; i < N_SENSORES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_temp_mux = temps[TEMP_W*i +: TEMP_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: snapshot, sampling, shadow levels, published outputs and
    // alarm debounce.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_temp_sel  <= '0;
            r_lim1      <= '0;
            r_lim2      <= '0;
            r_lim3      <= '0;
            r_lim4      <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_niveis    <= '0;
            r_nivel_max <= '0;
            r_pronto    <= 1'b0;
            r_alarme    <= 1'b0;
            for (int i = 0; i < N_SENSORES; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                CARREGA: begin
                    r_lim1 <= lim_temp1;
                    r_lim2 <= lim_temp2;
                    r_lim3 <= lim_temp3;
                    r_lim4 <= lim_temp4;
                    r_idx  <= '0;
                    r_max  <= '0;
                end
                MEDE: begin
                    r_temp_sel <= w_temp_mux;
                end
                REGISTRA: begin
                    for (int i = 0; i < N_SENSORES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_shadow[i] <= w_nivel;
                        end
                    end
                    if (w_nivel > r_max) begin
                        r_max <= w_nivel;
                    end
                    if (!w_ultimo) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                FIM: begin
                    for (int i = 0; i < N_SENSORES; i++) begin
                        r_niveis[2*i +: 2] <= r_shadow[i];
                    end
                    r_nivel_max <= r_max;
                    r_pronto    <= 1'b1;
                    if (r_max == NIVEL_CRITICO) begin
                        r_cnt    <= w_cnt_inc;
                        r_alarme <= (w_cnt_inc == C_CNT_MAX);
                    end else begin
                        r_cnt    <= '0;
                        r_alarme <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign niveis    = r_niveis;
    assign nivel_max = r_nivel_max;
    assign pronto    = r_pronto;
    assign alarme    = r_alarme;
    assign ocupado   = (r_estado != OCIOSO);
    assign db_estado = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_escalonador_temperaturas.sv
// ============================================================================
// Module      : tb_escalonador_temperaturas
// Description : Directed self-checking bench for escalonador_temperaturas
//               (N_SENSORES=4, ALARME_SCANS=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_escalonador_temperaturas;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic        continuo;
    logic [63:0] temps;
    logic [15:0] lim_temp1, lim_temp2, lim_temp3, lim_temp4;
    logic [7:0]  niveis;
    logic [1:0]  nivel_max;
    logic        pronto, ocupado, alarme;
    logic [2:0]  db_estado;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int n_pronto;
    int first_pronto;
    int ocupado_bad;

    always #5 clock = ~clock;

    escalonador_temperaturas #(
        .N_SENSORES   (4),
        .ALARME_SCANS (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .continuo  (continuo),
        .temps     (temps),
        .lim_temp1 (lim_temp1),
        .lim_temp2 (lim_temp2),
        .lim_temp3 (lim_temp3),
        .lim_temp4 (lim_temp4),
        .niveis    (niveis),
        .nivel_max (nivel_max),
        .pronto    (pronto),
        .ocupado   (ocupado),
        .alarme    (alarme),
        .db_estado (db_estado)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge right after iniciar was sampled.
    task automatic pulse_iniciar();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Counts rising edges until pronto is seen, bounded at 40.
    task automatic wait_pronto(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!pronto && n < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        iniciar   = 1'b0;
        continuo  = 1'b0;
        temps     = '0;
        lim_temp1 = 16'd20;
        lim_temp2 = 16'd25;
        lim_temp3 = 16'd30;
        lim_temp4 = 16'd35;
        repeat (2) @(negedge clock);
        check("rst_niveis",    niveis,    8'h00);
        check("rst_nivel_max", nivel_max, 2'd0);
        check("rst_pronto",    pronto,    1'b0);
        check("rst_ocupado",   ocupado,   1'b0);
        check("rst_alarme",    alarme,    1'b0);
        check("rst_estado",    db_estado, 3'd0);
        reset = 1'b0;

        // 1: basic scan and latency
        temps = {16'd40, 16'd28, 16'd22, 16'd10};
        pulse_iniciar();
        check("t1_ocupado", ocupado, 1'b1);
        wait_pronto(lat);
        check("t1_latency",   lat,       10);
        check("t1_niveis",    niveis,    8'hE4);
        check("t1_nivel_max", nivel_max, 2'd3);
        check("t1_alarme",    alarme,    1'b0);
        @(negedge clock);
        check("t1_pronto_pulse", pronto, 1'b0);
        check("t1_idle",         ocupado, 1'b0);

        // 2: boundaries
        temps = {16'd35, 16'd30, 16'd25, 16'd20};
        pulse_iniciar();
        wait_pronto(lat);
        check("t2a_niveis", niveis,    8'hE4);
        check("t2a_max",    nivel_max, 2'd3);
        temps = {16'd19, 16'd30, 16'd26, 16'd21};
        pulse_iniciar();
        wait_pronto(lat);
        check("t2b_niveis", niveis,    8'h29);
        check("t2b_max",    nivel_max, 2'd2);
        temps = {16'd36, 16'd31, 16'd0, 16'd0};
        pulse_iniciar();
        wait_pronto(lat);
        check("t2c_niveis", niveis,    8'hF0);
        check("t2c_max",    nivel_max, 2'd3);
        check("t2c_alarme", alarme,    1'b0);

        // 3: mid-scan changes of lim_temp1 and sensor 0
        temps = {16'd40, 16'd28, 16'd22, 16'd10};
        pulse_iniciar();
        @(negedge clock);
        lim_temp1     = 16'd50;
        temps[15:0]   = 16'd60;
        check("t3_hold_niveis", niveis,    8'hF0);
        check("t3_hold_max",    nivel_max, 2'd3);
        wait_pronto(lat);
        check("t3_latency", lat,       9);
        check("t3_niveis",  niveis,    8'hE7);
        check("t3_max",     nivel_max, 2'd3);
        check("t3_alarme",  alarme,    1'b0);
        lim_temp1 = 16'd20;

        // 4: continuous scans and alarm debounce
        temps = {16'd10, 16'd10, 16'd10, 16'd10};
        pulse_iniciar();
        wait_pronto(lat);
        check("t4_cool_niveis", niveis,    8'h00);
        check("t4_cool_max",    nivel_max, 2'd0);
        temps    = {16'd10, 16'd10, 16'd10, 16'd40};
        continuo = 1'b1;
        pulse_iniciar();
        wait_pronto(lat);
        check("t4_fim1_niveis", niveis, 8'h03);
        check("t4_fim1_alarme", alarme, 1'b0);
        wait_pronto(lat);
        check("t4_period",      lat,    10);
        check("t4_fim2_alarme", alarme, 1'b0);
        wait_pronto(lat);
        check("t4_fim3_alarme", alarme, 1'b1);
        check("t4_fim3_busy",   ocupado, 1'b1);
        wait_pronto(lat);
        check("t4_fim4_alarme", alarme, 1'b1);
        temps[15:0] = 16'd10;
        continuo    = 1'b0;
        wait_pronto(lat);
        check("t4_fim5_alarme", alarme,    1'b0);
        check("t4_fim5_max",    nivel_max, 2'd0);
        check("t4_fim5_idle",   ocupado,   1'b0);

        // 5: iniciar re-pulsed while busy
        temps        = {16'd21, 16'd26, 16'd31, 16'd36};
        n_pronto     = 0;
        first_pronto = 0;
        ocupado_bad  = 0;
        @(negedge clock);
        iniciar = 1'b1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clock);
            iniciar = (cyc == 2 || cyc == 5);
            if (pronto) begin
                n_pronto++;
                if (first_pronto == 0) first_pronto = cyc;
            end
            if (cyc <= 10 && !ocupado) ocupado_bad++;
        end
        check("t5_pronto_count", n_pronto,     1);
        check("t5_pronto_cycle", first_pronto, 11);
        check("t5_ocupado_gap",  ocupado_bad,  0);
        check("t5_niveis",       niveis,       8'h6F);
        check("t5_max",          nivel_max,    2'd3);

        // 6: asynchronous reset in the middle of a scan
        temps = {16'd40, 16'd28, 16'd22, 16'd10};
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (6) @(negedge clock);
        check("t6_in_registra", db_estado, 3'd3);
        reset = 1'b1;
        #1;
        check("t6_rst_niveis",  niveis,    8'h00);
        check("t6_rst_max",     nivel_max, 2'd0);
        check("t6_rst_ocupado", ocupado,   1'b0);
        check("t6_rst_pronto",  pronto,    1'b0);
        check("t6_rst_alarme",  alarme,    1'b0);
        check("t6_rst_estado",  db_estado, 3'd0);
        @(negedge clock);
        reset = 1'b0;
        temps = {16'd30, 16'd30, 16'd30, 16'd30};
        pulse_iniciar();
        wait_pronto(lat);
        check("t6_latency", lat,       10);
        check("t6_niveis",  niveis,    8'hAA);
        check("t6_max",     nivel_max, 2'd2);
        check("t6_alarme",  alarme,    1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
